// File: rtl/dma_bus_arbiter.sv
// CPU-side DMA handshake responder: turns a device start interrupt into a cmd pulse,
// grants the data bus to the DMA engine only between pipeline accesses, and stalls the pipeline meanwhile.
module dma_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int PENDING_MAX    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dma_start_int,
  input  logic        dma_end_int,
  input  logic        BR,
  input  logic        d_busy,
  output logic        cmd,
  output logic        BG,
  output logic        d_stall,
  output logic        dma_active,
  output logic        dma_error,
  output logic [1:0]  pending,
  output logic [15:0] grant_cycles
);

  localparam int         TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] P_MAX = 2'(PENDING_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_REQ, GRANTED} state_t;

  state_t          state, next_state;
  logic [TW-1:0]   tmo_cnt;
  logic            end_seen;
  logic            tmo_hit;
  logic            overflow;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // The last idle WAIT_REQ cycle before the budget runs out; no BR and no end this cycle.
  assign tmo_hit  = (state == WAIT_REQ) && !dma_end_int && !BR &&
                    (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign overflow = (state != IDLE) && dma_start_int && (pending == P_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (dma_start_int || pending != 2'd0) next_state = ISSUE;
      ISSUE:    next_state = WAIT_REQ;
      WAIT_REQ: begin
        if (dma_end_int)      next_state = IDLE;
        else if (BR && !d_busy) next_state = GRANTED;
        else if (tmo_hit)     next_state = IDLE;
      end
      GRANTED:  if (!BR) next_state = (end_seen || dma_end_int) ? IDLE : WAIT_REQ;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    cmd        = 1'b0;
    BG         = 1'b0;
    d_stall    = 1'b0;
    dma_active = 1'b0;
    cmd        = (state == ISSUE);
    BG         = (state == GRANTED);
    d_stall    = (state == GRANTED) || ((state == WAIT_REQ) && BR);
    dma_active = (state != IDLE);
  end

  // Held at zero outside WAIT_REQ, so every entry starts a fresh budget.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    tmo_cnt <= '0;
    else if (state != WAIT_REQ)      tmo_cnt <= '0;
    else if (!dma_end_int && !BR)    tmo_cnt <= tmo_cnt + TW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 2'd0;
    end else if (state == IDLE) begin
      if (!dma_start_int && pending != 2'd0) pending <= pending - 2'd1;
    end else if (dma_start_int && pending != P_MAX) begin
      pending <= pending + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                       dma_error <= 1'b0;
    else if (state == IDLE && next_state == ISSUE)      dma_error <= 1'b0;
    else if (tmo_hit || overflow)                       dma_error <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               end_seen <= 1'b0;
    else if (state != GRANTED)  end_seen <= 1'b0;
    else if (!BR)               end_seen <= 1'b0;
    else if (dma_end_int)       end_seen <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               grant_cycles <= 16'd0;
    else if (state == GRANTED)  grant_cycles <= sat_inc16(grant_cycles);
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Table-driven bench for dma_bus_arbiter; each row gives one cycle's inputs and the outputs expected in that cycle.
module tb_dma_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dma_start_int, dma_end_int, BR, d_busy;
  logic        cmd, BG, d_stall, dma_active, dma_error;
  logic [1:0]  pending;
  logic [15:0] grant_cycles;

  always #5 clk = ~clk;

  dma_bus_arbiter #(.TIMEOUT_CYCLES(64), .PENDING_MAX(3)) dut (
    .clk(clk), .reset_n(reset_n), .dma_start_int(dma_start_int), .dma_end_int(dma_end_int),
    .BR(BR), .d_busy(d_busy), .cmd(cmd), .BG(BG), .d_stall(d_stall), .dma_active(dma_active),
    .dma_error(dma_error), .pending(pending), .grant_cycles(grant_cycles)
  );

  // stim = {start, end, BR, d_busy}; exp = {cmd, BG, d_stall, dma_active, dma_error, pending[1:0]}
  typedef struct {
    logic [3:0] stim;
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [15:0] gc0;

  function automatic void add(input string nm, input logic [3:0] s, input logic [6:0] e);
    vec_t v;
    v.stim = s;
    v.exp  = e;
    v.name = nm;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] s, input logic [6:0] e, input string nm);
    logic [6:0] want;
    {dma_start_int, dma_end_int, BR, d_busy} = s;
    sb_q.push_back(e);
    #2;
    want = sb_q.pop_front();
    check(nm, {25'd0, cmd, BG, d_stall, dma_active, dma_error, pending}, {25'd0, want});
    @(posedge clk);
    #1;
  endtask

  task automatic run_table();
    foreach (vecs[i]) drive(vecs[i].stim, vecs[i].exp, $sformatf("%s[%0d]", vecs[i].name, i));
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    {dma_start_int, dma_end_int, BR, d_busy} = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {25'd0, cmd, BG, d_stall, dma_active, dma_error, pending}, 32'd0);
    check("reset_grant_cycles", {16'd0, grant_cycles}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic transfer
    add("basic", 4'b1000, 7'b0000_0_00);
    add("basic", 4'b0000, 7'b1001_0_00);
    add("basic", 4'b0000, 7'b0001_0_00);
    add("basic", 4'b0010, 7'b0011_0_00);
    for (int c = 4; c <= 13; c++) add("basic", 4'b0010, 7'b0111_0_00);
    add("basic", 4'b0110, 7'b0111_0_00);
    add("basic", 4'b0000, 7'b0111_0_00);
    add("basic", 4'b0000, 7'b0000_0_00);
    run_table();
    check("basic_grant_cycles", {16'd0, grant_cycles}, 32'd12);

    // Cycle stealing: three 4-cycle BR bursts separated by 2 idle cycles
    gc0 = grant_cycles;
    add("steal", 4'b1000, 7'b0000_0_00);
    add("steal", 4'b0000, 7'b1001_0_00);
    for (int b = 0; b < 3; b++) begin
      add("steal", 4'b0010, 7'b0011_0_00);
      for (int k = 0; k < 3; k++) add("steal", 4'b0010, 7'b0111_0_00);
      add("steal", (b == 2) ? 4'b0100 : 4'b0000, 7'b0111_0_00);
      if (b < 2) add("steal", 4'b0000, 7'b0001_0_00);
    end
    add("steal", 4'b0000, 7'b0000_0_00);
    run_table();
    check("steal_grant_delta", {16'd0, grant_cycles - gc0}, 32'd12);

    // Grant deferral while the pipeline is busy
    add("defer", 4'b1000, 7'b0000_0_00);
    add("defer", 4'b0000, 7'b1001_0_00);
    for (int k = 0; k < 3; k++) add("defer", 4'b0011, 7'b0011_0_00);
    add("defer", 4'b0010, 7'b0011_0_00);
    add("defer", 4'b0010, 7'b0111_0_00);
    add("defer", 4'b0100, 7'b0111_0_00);
    add("defer", 4'b0000, 7'b0000_0_00);
    run_table();

    // Queued starts, overflow, drain, and same-cycle events
    add("queue", 4'b1000, 7'b0000_0_00);
    add("queue", 4'b1000, 7'b1001_0_00);
    add("queue", 4'b1000, 7'b0001_0_01);
    add("queue", 4'b1000, 7'b0001_0_10);
    add("queue", 4'b1000, 7'b0001_0_11);
    add("queue", 4'b0100, 7'b0001_1_11);
    add("queue", 4'b0000, 7'b0000_1_11);
    add("queue", 4'b0000, 7'b1001_0_10);
    add("queue", 4'b0100, 7'b0001_0_10);
    add("queue", 4'b1000, 7'b0000_0_10);
    add("queue", 4'b0000, 7'b1001_0_10);
    add("queue", 4'b0100, 7'b0001_0_10);
    add("queue", 4'b0000, 7'b0000_0_10);
    add("queue", 4'b0000, 7'b1001_0_01);
    add("queue", 4'b0100, 7'b0001_0_01);
    add("queue", 4'b0000, 7'b0000_0_01);
    add("queue", 4'b0000, 7'b1001_0_00);
    add("queue", 4'b1100, 7'b0001_0_00);
    add("queue", 4'b0000, 7'b0000_0_01);
    add("queue", 4'b0000, 7'b1001_0_00);
    add("queue", 4'b0100, 7'b0001_0_00);
    add("queue", 4'b0000, 7'b0000_0_00);
    run_table();

    // Timeout: no BR and no end after cmd
    drive(4'b1000, 7'b0000_0_00, "tmo_start");
    drive(4'b0000, 7'b1001_0_00, "tmo_cmd");
    for (int k = 1; k <= 64; k++) drive(4'b0000, 7'b0001_0_00, $sformatf("tmo_wait[%0d]", k));
    drive(4'b1000, 7'b0000_1_00, "tmo_idle_error");
    drive(4'b0000, 7'b1001_0_00, "tmo_issue_clears_error");
    drive(4'b0100, 7'b0001_0_00, "tmo_end");
    drive(4'b0000, 7'b0000_0_00, "tmo_back_idle");

    // Reset asserted mid-grant
    drive(4'b1000, 7'b0000_0_00, "rst_start");
    drive(4'b0000, 7'b1001_0_00, "rst_issue");
    drive(4'b0010, 7'b0011_0_00, "rst_wait");
    drive(4'b0010, 7'b0111_0_00, "rst_granted");
    reset_n = 1'b0;
    #1;
    check("rst_async_outputs", {25'd0, cmd, BG, d_stall, dma_active, dma_error, pending}, 32'd0);
    check("rst_async_grant_cycles", {16'd0, grant_cycles}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_held_outputs", {25'd0, cmd, BG, d_stall, dma_active, dma_error, pending}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    BR = 1'b0;
    @(posedge clk);
    #1;
    check("rst_released_outputs", {25'd0, cmd, BG, d_stall, dma_active, dma_error, pending}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
